// File: rtl/multiply_controller_if.sv
// -----------------------------------------------------------------------------
// multiply_controller_if
//
// Groups every non-clock, non-reset signal of the multiply controller.
//
// Signals:
//   Start        request to begin a multiplication (sampled only in IDLE)
//   Abort        cancel an in-flight multiplication (build-option dependent)
//   OperandA     4-bit multiplicand, captured at the accept edge
//   OperandB     4-bit multiplier, captured at the accept edge
//   Product      8-bit product returned by the DataUnit
//   Multiplicant latched OperandA, drives the DataUnit
//   Multiplier   latched OperandB, drives the DataUnit
//   Shift1       DataUnit control word, upper half
//   Shift0       DataUnit control word, lower half
//   Busy         controller is not idle
//   Done         one-cycle completion strobe (Product is valid then)
//   Result       last captured product, held
//   ResultValid  Result holds a completed product
//   Iteration    current add/shift iteration index, 0..3
//
// Modports:
//   master  user/DataUnit side: drives requests, operands and Product
//   slave   controller side: drives the DataUnit controls and status
// -----------------------------------------------------------------------------
interface multiply_controller_if;
    logic       Start;
    logic       Abort;
    logic [3:0] OperandA;
    logic [3:0] OperandB;
    logic [7:0] Product;
    logic [3:0] Multiplicant;
    logic [3:0] Multiplier;
    logic [2:0] Shift1;
    logic [2:0] Shift0;
    logic       Busy;
    logic       Done;
    logic [7:0] Result;
    logic       ResultValid;
    logic [1:0] Iteration;

    modport master (
        output Start, Abort, OperandA, OperandB, Product,
        input  Multiplicant, Multiplier, Shift1, Shift0,
               Busy, Done, Result, ResultValid, Iteration
    );

    modport slave (
        input  Start, Abort, OperandA, OperandB, Product,
        output Multiplicant, Multiplier, Shift1, Shift0,
               Busy, Done, Result, ResultValid, Iteration
    );
endinterface

// File: rtl/multiply_controller.sv
// -----------------------------------------------------------------------------
// multiply_controller
//
// Sequencer for the 4x4 shift-add multiplier DataUnit. On an accepted Start it
// latches both operands, walks the DataUnit through LOAD, four TEST steps with
// three SHIFT steps between them, FINAL and DONE, then captures the 8-bit
// Product into a held Result register.
//
// Ports:
//   clock   system clock, rising-edge active
//   reset   asynchronous, active-high; forces IDLE and all output reset values
//   bus     multiply_controller_if.slave (operands, Start/Abort, Product in;
//           DataUnit operands/control words and status out)
//
// Build option:
//   MULT_CTRL_ABORT_EN  when defined, Abort in LOAD/TEST/SHIFT/FINAL returns
//                       the FSM to IDLE without completing. When undefined the
//                       Abort input is ignored and every operation completes.
//
// Every output is a flop: control words, Busy and Done are loaded from the
// next-state value so they line up with the state they describe, with no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module multiply_controller (
    input  logic               clock,
    input  logic               reset,
    multiply_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_SHIFT = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] iter_q, iter_d;
    logic       accept;
    logic       abort_hit;

    logic [3:0] mcand_q;
    logic [3:0] mplier_q;
    logic [2:0] shift1_q;
    logic [2:0] shift0_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] result_q;
    logic       result_valid_q;

    // Control word for the DataUnit in each state.
    function automatic logic [2:0] shift1_of(input state_t s);
        case (s)
            S_LOAD:  shift1_of = 3'b101;
            S_TEST:  shift1_of = 3'b010;
            S_SHIFT: shift1_of = 3'b111;
            S_FINAL: shift1_of = 3'b011;
            default: shift1_of = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] shift0_of(input state_t s);
        case (s)
            S_LOAD:  shift0_of = 3'b101;
            S_TEST:  shift0_of = 3'b010;
            default: shift0_of = 3'b000;
        endcase
    endfunction

`ifdef MULT_CTRL_ABORT_EN
    // DONE is deliberately excluded: once the product is on the bus the
    // completion wins over a late cancel.
    assign abort_hit = bus.Abort &&
                       ((state_q == S_LOAD)  || (state_q == S_TEST) ||
                        (state_q == S_SHIFT) || (state_q == S_FINAL));
`else
    logic unused_abort;
    assign unused_abort = bus.Abort;
    assign abort_hit    = 1'b0;
`endif

    // Next-state and iteration counter.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                    iter_d  = 2'd0;
                end
            end
            S_LOAD:  state_d = S_TEST;
            // Iteration saturates at 3 by construction: the last TEST exits to
            // FINAL instead of another SHIFT, so the counter never wraps.
            S_TEST:  state_d = (iter_q == 2'd3) ? S_FINAL : S_SHIFT;
            S_SHIFT: begin
                state_d = S_TEST;
                iter_d  = iter_q + 2'd1;
            end
            S_FINAL: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            iter_d  = 2'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            iter_q         <= 2'd0;
            mcand_q        <= 4'd0;
            mplier_q       <= 4'd0;
            shift1_q       <= 3'b000;
            shift0_q       <= 3'b000;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= 8'h00;
            result_valid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            shift1_q <= shift1_of(state_d);
            shift0_q <= shift0_of(state_d);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);

            // Operands are only touched on accept, so they persist across IDLE
            // and are immune to Start pulses while busy.
            if (accept) begin
                mcand_q        <= bus.OperandA;
                mplier_q       <= bus.OperandB;
                result_valid_q <= 1'b0;
            end

            // The edge that ends DONE is the one at which Product is valid.
            if (state_q == S_DONE) begin
                result_q       <= bus.Product;
                result_valid_q <= 1'b1;
            end
        end
    end

    assign bus.Multiplicant = mcand_q;
    assign bus.Multiplier   = mplier_q;
    assign bus.Shift1       = shift1_q;
    assign bus.Shift0       = shift0_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;
    assign bus.Result       = result_q;
    assign bus.ResultValid  = result_valid_q;
    assign bus.Iteration    = iter_q;

endmodule
